// File: rtl/fe_de_iq.sv
// Fetch-to-decode instruction queue with flush handling and a small branch target buffer.
// The head entry is presented to decode; the BTB captures issued branch instructions.
module fe_de_iq #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned BTB_ENTRIES = 4,
    parameter int unsigned BTB_DLY     = 10,
    parameter int unsigned CAUSE_W     = 5
) (
    input  logic                   clk,
    input  logic                   cpurst_n,
    input  logic                   fet_valid,
    output logic                   fet_ready,
    input  logic [31:0]            fetch_pc,
    input  logic [31:0]            rv32_instr_todec,
    input  logic [15:0]            rv16_instr_todec,
    input  logic                   fe2de_rv16,
    input  logic                   predict_bxxtaken,
    input  logic                   fet_is_x1,
    input  logic                   fet_is_xn,
    input  logic                   g_int,
    input  logic [CAUSE_W-1:0]     causecode_int,
    input  logic                   de_stall,
    input  logic                   exe_stall,
    input  logic                   memacc_stall,
    input  logic                   fet_flush,
    input  logic                   branch_predict_err,
    input  logic                   fence_stall,
    input  logic                   de2fe_branch,
    input  logic                   de2ex_inst_valid,
    input  logic [31:0]            btb_lookup_pc,
    output logic                   fe2de_valid,
    output logic [31:0]            fe2de_pc_ffout,
    output logic [31:0]            fe2de_instr_ffout,
    output logic                   fe2de_rv16_ffout,
    output logic                   fe2de_predict_bxxtaken_ffout,
    output logic                   fet_is_x1_ffout,
    output logic                   fet_is_xn_ffout,
    output logic                   fe2de_g_int_ffout,
    output logic [CAUSE_W-1:0]     fe2de_causecode_int_ffout,
    output logic                   fe_de_stall,
    output logic                   de2ex_inst_valid_real,
    output logic                   btb_hit,
    output logic [31:0]            btb_instr,
    output logic                   btb_valid,
    output logic [$clog2(DEPTH):0] iq_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 1;
    localparam logic [3:0]  DLY_C = 4'(BTB_DLY);

    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        instr;
        logic [15:0]        i16;
        logic               rv16;
        logic               bxx;
        logic               x1;
        logic               xn;
        logic               gint;
        logic [CAUSE_W-1:0] cause;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic [31:0]     last_pc_q;
    entry_t          head_e, new_e;
    logic            stall, push, pop, flush;

    logic [31:0]      btb_pc_q  [BTB_ENTRIES];
    logic [31:0]      btb_ins_q [BTB_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_v_q;
    logic [BW-1:0]    alloc_q, alloc_d, cap_idx, w_idx;
    logic [3:0]       dly_q, dly_d;
    logic             btb_en_q, btb_en_d;
    logic             capture, cap_hit, lk_hit;
    logic [31:0]      lk_ins, cap_data;

    assign stall   = de_stall | exe_stall | memacc_stall;
    // DEPTH is a power of two, so the count MSB is set exactly when full.
    assign fet_ready = ~count_q[AW];
    assign push    = fet_valid & fet_ready;
    assign pop     = fe2de_valid & ~stall;
    assign flush   = (fet_flush | branch_predict_err | fence_stall) & ~stall;
    assign iq_count = count_q;
    assign fe_de_stall = stall;
    assign de2ex_inst_valid_real = de2ex_inst_valid & ~stall;

    assign head_e = mem_q[rptr_q];
    assign new_e  = '{pc: fetch_pc, instr: rv32_instr_todec, i16: rv16_instr_todec,
                      rv16: fe2de_rv16, bxx: predict_bxxtaken, x1: fet_is_x1,
                      xn: fet_is_xn, gint: g_int, cause: causecode_int};

    always_comb begin
        fe2de_valid                  = (count_q != '0);
        fe2de_pc_ffout               = fe2de_valid ? head_e.pc : last_pc_q;
        fe2de_instr_ffout            = fe2de_valid ? head_e.instr : '0;
        fe2de_rv16_ffout             = fe2de_valid & head_e.rv16;
        fe2de_predict_bxxtaken_ffout = fe2de_valid & head_e.bxx;
        fet_is_x1_ffout              = fe2de_valid & head_e.x1;
        fet_is_xn_ffout              = fe2de_valid & head_e.xn;
        fe2de_g_int_ffout            = fe2de_valid & head_e.gint;
        fe2de_causecode_int_ffout    = fe2de_valid ? head_e.cause : '0;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            last_pc_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (pop) last_pc_q <= head_e.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= new_e;
    end

    assign capture  = btb_en_q & de2ex_inst_valid_real;
    assign cap_data = fe2de_rv16_ffout ? {16'h0000, head_e.i16} : fe2de_instr_ffout;

    always_comb begin
        cap_hit = 1'b0;
        cap_idx = '0;
        lk_hit  = 1'b0;
        lk_ins  = '0;
        for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
            if (btb_v_q[i] && (btb_pc_q[i] == fe2de_pc_ffout)) begin
                cap_hit = 1'b1;
                cap_idx = BW'(i);
            end
            if (btb_v_q[i] && (btb_pc_q[i] == btb_lookup_pc)) begin
                lk_hit = 1'b1;
                lk_ins = btb_ins_q[i];
            end
        end
    end

    assign btb_valid = (dly_q == DLY_C);
    assign btb_hit   = btb_valid & lk_hit;
    assign btb_instr = btb_hit ? lk_ins : '0;
    assign w_idx     = cap_hit ? cap_idx : alloc_q;

    always_comb begin
        alloc_d = alloc_q;
        if (capture && !cap_hit)
            alloc_d = (alloc_q == BW'(BTB_ENTRIES - 1)) ? '0 : alloc_q + 1'b1;
        btb_en_d = btb_en_q;
        if (capture)           btb_en_d = 1'b0;
        else if (de2fe_branch) btb_en_d = 1'b1;
        dly_d = (dly_q == DLY_C) ? dly_q : dly_q + 1'b1;
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            btb_v_q  <= '0;
            alloc_q  <= '0;
            btb_en_q <= 1'b0;
            dly_q    <= '0;
        end else begin
            alloc_q  <= alloc_d;
            btb_en_q <= btb_en_d;
            dly_q    <= dly_d;
            if (capture) btb_v_q[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            btb_pc_q[w_idx]  <= fe2de_pc_ffout;
            btb_ins_q[w_idx] <= cap_data;
        end
    end

endmodule

// File: tb/tb_fe_de_iq.sv
// Scoreboard bench for fe_de_iq: a queue-based reference model is advanced every cycle and
// all outputs are compared at the falling edge; directed sequences precede random traffic.
module tb_fe_de_iq;

    localparam int DEPTH = 4;
    localparam int NBTB  = 4;
    localparam int DLY   = 10;
    localparam int CW    = 5;

    logic        clk = 1'b0, cpurst_n = 1'b0;
    logic        fet_valid, fet_ready;
    logic [31:0] fetch_pc, rv32_instr_todec;
    logic [15:0] rv16_instr_todec;
    logic        fe2de_rv16, predict_bxxtaken, fet_is_x1, fet_is_xn, g_int;
    logic [CW-1:0] causecode_int;
    logic        de_stall, exe_stall, memacc_stall;
    logic        fet_flush, branch_predict_err, fence_stall;
    logic        de2fe_branch, de2ex_inst_valid;
    logic [31:0] btb_lookup_pc;
    logic        fe2de_valid;
    logic [31:0] fe2de_pc_ffout, fe2de_instr_ffout;
    logic        fe2de_rv16_ffout, fe2de_predict_bxxtaken_ffout, fet_is_x1_ffout;
    logic        fet_is_xn_ffout, fe2de_g_int_ffout;
    logic [CW-1:0] fe2de_causecode_int_ffout;
    logic        fe_de_stall, de2ex_inst_valid_real, btb_hit, btb_valid;
    logic [31:0] btb_instr;
    logic [$clog2(DEPTH):0] iq_count;

    fe_de_iq #(.DEPTH(DEPTH), .BTB_ENTRIES(NBTB), .BTB_DLY(DLY), .CAUSE_W(CW)) dut (
        .clk(clk), .cpurst_n(cpurst_n), .fet_valid(fet_valid), .fet_ready(fet_ready),
        .fetch_pc(fetch_pc), .rv32_instr_todec(rv32_instr_todec),
        .rv16_instr_todec(rv16_instr_todec), .fe2de_rv16(fe2de_rv16),
        .predict_bxxtaken(predict_bxxtaken), .fet_is_x1(fet_is_x1), .fet_is_xn(fet_is_xn),
        .g_int(g_int), .causecode_int(causecode_int), .de_stall(de_stall),
        .exe_stall(exe_stall), .memacc_stall(memacc_stall), .fet_flush(fet_flush),
        .branch_predict_err(branch_predict_err), .fence_stall(fence_stall),
        .de2fe_branch(de2fe_branch), .de2ex_inst_valid(de2ex_inst_valid),
        .btb_lookup_pc(btb_lookup_pc), .fe2de_valid(fe2de_valid),
        .fe2de_pc_ffout(fe2de_pc_ffout), .fe2de_instr_ffout(fe2de_instr_ffout),
        .fe2de_rv16_ffout(fe2de_rv16_ffout),
        .fe2de_predict_bxxtaken_ffout(fe2de_predict_bxxtaken_ffout),
        .fet_is_x1_ffout(fet_is_x1_ffout), .fet_is_xn_ffout(fet_is_xn_ffout),
        .fe2de_g_int_ffout(fe2de_g_int_ffout),
        .fe2de_causecode_int_ffout(fe2de_causecode_int_ffout),
        .fe_de_stall(fe_de_stall), .de2ex_inst_valid_real(de2ex_inst_valid_real),
        .btb_hit(btb_hit), .btb_instr(btb_instr), .btb_valid(btb_valid),
        .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, instr;
        logic [15:0] i16;
        logic        rv16, bxx, x1, xn, gint;
        logic [CW-1:0] cause;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] live_q[$];
    logic [31:0] bdata[logic [31:0]];
    logic [31:0] last_pc_m;
    bit          en_m;
    int          dly_m;
    int          vectors = 0, miscompares = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic bit is_live(input logic [31:0] pc);
        foreach (live_q[i]) if (live_q[i] == pc) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: compare against the model, then advance the model by the coming clock edge.
    initial forever begin
        @(negedge clk);
        if (!cpurst_n) begin
            exp_q.delete(); live_q.delete(); bdata.delete();
            last_pc_m = '0; en_m = 1'b0; dly_m = 0;
        end
        begin
            automatic int n = exp_q.size();
            automatic bit st = de_stall | exe_stall | memacc_stall;
            automatic ent_t e = '{pc: last_pc_m, instr: 32'h0, i16: 16'h0, rv16: 1'b0, bxx: 1'b0,
                                  x1: 1'b0, xn: 1'b0, gint: 1'b0, cause: '0};
            automatic bit ehit;
            automatic logic [31:0] hdat;
            if (n != 0) e = exp_q[0];
            ehit = (dly_m == DLY) && is_live(btb_lookup_pc);
            chk("fet_ready", fet_ready, n < DEPTH);
            chk("fe2de_valid", fe2de_valid, n != 0);
            chk("iq_count", iq_count, n);
            chk("head_pc", fe2de_pc_ffout, e.pc);
            chk("head_instr", fe2de_instr_ffout, e.instr);
            chk("head_flags", {fe2de_rv16_ffout, fe2de_predict_bxxtaken_ffout, fet_is_x1_ffout,
                               fet_is_xn_ffout, fe2de_g_int_ffout, fe2de_causecode_int_ffout},
                {e.rv16, e.bxx, e.x1, e.xn, e.gint, e.cause});
            chk("fe_de_stall", fe_de_stall, st);
            chk("inst_valid_real", de2ex_inst_valid_real, de2ex_inst_valid && !st);
            chk("btb_valid", btb_valid, dly_m == DLY);
            chk("btb_hit", btb_hit, ehit);
            chk("btb_instr", btb_instr, ehit ? bdata[btb_lookup_pc] : 32'h0);
            if (cpurst_n) begin
                hdat = (n == 0) ? 32'h0 : (e.rv16 ? {16'h0, e.i16} : e.instr);
                if (en_m && de2ex_inst_valid && !st) begin
                    if (!is_live(e.pc)) begin
                        live_q.push_back(e.pc);
                        if (live_q.size() > NBTB) live_q.delete(0);
                    end
                    bdata[e.pc] = hdat;
                    en_m = 1'b0;
                end else if (de2fe_branch) en_m = 1'b1;
                if (dly_m < DLY) dly_m++;
                if (n != 0 && !st) begin
                    last_pc_m = exp_q[0].pc;
                    exp_q.delete(0);
                end
                if ((fet_flush || branch_predict_err || fence_stall) && !st) exp_q.delete();
                else if (fet_valid && n < DEPTH)
                    exp_q.push_back('{pc: fetch_pc, instr: rv32_instr_todec, i16: rv16_instr_todec,
                                      rv16: fe2de_rv16, bxx: predict_bxxtaken, x1: fet_is_x1,
                                      xn: fet_is_xn, gint: g_int, cause: causecode_int});
            end
        end
    end

    task automatic clr();
        fet_valid = 0; fetch_pc = '0; rv32_instr_todec = '0; rv16_instr_todec = '0;
        fe2de_rv16 = 0; predict_bxxtaken = 0; fet_is_x1 = 0; fet_is_xn = 0; g_int = 0;
        causecode_int = '0; de_stall = 0; exe_stall = 0; memacc_stall = 0;
        fet_flush = 0; branch_predict_err = 0; fence_stall = 0;
        de2fe_branch = 0; de2ex_inst_valid = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic rv16, input logic [15:0] i16,
                         input logic [31:0] ins);
        fet_valid = 1; fetch_pc = pc; fe2de_rv16 = rv16; rv16_instr_todec = i16;
        rv32_instr_todec = ins;
    endtask

    task automatic capture(input logic [31:0] pc, input logic [31:0] ins);
        clr(); fetch(pc, 1'b0, 16'h0, ins); de2fe_branch = 1; cyc();
        clr(); de2ex_inst_valid = 1; cyc();
        clr();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr(); btb_lookup_pc = 32'h200;
        repeat (2) @(posedge clk);
        #1 cpurst_n = 1;
        // BTB capture of a compressed branch early, so the delay gate is exercised
        fetch(32'h200, 1'b1, 16'h4082, 32'hDEAD_BEEF); de2fe_branch = 1; cyc();
        clr(); de2ex_inst_valid = 1; cyc();
        clr(); repeat (12) cyc();
        chk("btb_rv16_capture", btb_instr, 32'h0000_4082);
        // streaming with no stall
        for (int i = 0; i < 4; i++) begin
            fetch(32'h100 + 4 * i, 1'b0, 16'h0, $urandom); g_int = 1'(i); cyc();
        end
        clr(); cyc();
        // fill while stalled, 5th push refused
        for (int i = 0; i < 5; i++) begin
            clr(); de_stall = 1; fetch(32'h100 + 4 * i, 1'b0, 16'h0, 32'h1000 + i); cyc();
        end
        chk("full_count", iq_count, 4);
        chk("full_ready", fet_ready, 0);
        clr(); repeat (5) cyc();
        chk("bubble_pc", fe2de_pc_ffout, 32'h10C);
        chk("bubble_instr", fe2de_instr_ffout, 0);
        // flush blocked by stall, then taken
        for (int i = 0; i < 3; i++) begin
            clr(); de_stall = 1; fetch(32'h300 + 4 * i, 1'b0, 16'h0, $urandom); cyc();
        end
        clr(); exe_stall = 1; branch_predict_err = 1; fetch(32'h30C, 1'b0, 16'h0, 32'h5); cyc();
        chk("stalled_flush_count", iq_count, 4);
        clr(); branch_predict_err = 1; fetch(32'h310, 1'b0, 16'h0, 32'h6); cyc();
        chk("flush_count", iq_count, 0);
        chk("flush_valid", fe2de_valid, 0);
        clr(); cyc();
        // round-robin eviction and in-place update
        for (int k = 0; k < 5; k++) capture(32'h400 + 4 * k, 32'hA000 + k);
        btb_lookup_pc = 32'h400; #1 chk("evicted_miss", btb_hit, 0);
        capture(32'h404, 32'hBEEF);
        btb_lookup_pc = 32'h404; #1 chk("update_instr", btb_instr, 32'hBEEF);
        capture(32'h500, 32'hC0DE);
        btb_lookup_pc = 32'h404; #1 chk("ptr_unchanged_miss", btb_hit, 0);
        btb_lookup_pc = 32'h408; #1 chk("ptr_unchanged_hit", btb_hit, 1);
        cyc();
        // random traffic with an asynchronous reset in the middle
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) begin
                @(posedge clk); #3 cpurst_n = 0;
                #1;
                chk("async_rst_count", iq_count, 0);
                chk("async_rst_valid", fe2de_valid, 0);
                chk("async_rst_pc", fe2de_pc_ffout, 0);
                chk("async_rst_btb", {btb_hit, btb_valid}, 0);
                @(posedge clk); #1 cpurst_n = 1;
            end
            fet_valid = ($urandom_range(0, 9) < 7);
            fetch_pc = 32'h600 + 4 * $urandom_range(0, 7);
            rv32_instr_todec = $urandom; rv16_instr_todec = 16'($urandom);
            fe2de_rv16 = 1'($urandom); predict_bxxtaken = 1'($urandom);
            fet_is_x1 = 1'($urandom); fet_is_xn = 1'($urandom); g_int = 1'($urandom);
            causecode_int = CW'($urandom);
            de_stall = ($urandom_range(0, 99) < 15);
            exe_stall = ($urandom_range(0, 99) < 10);
            memacc_stall = ($urandom_range(0, 99) < 10);
            fet_flush = ($urandom_range(0, 99) < 4);
            branch_predict_err = ($urandom_range(0, 99) < 4);
            fence_stall = ($urandom_range(0, 99) < 3);
            de2fe_branch = ($urandom_range(0, 99) < 30);
            de2ex_inst_valid = ($urandom_range(0, 99) < 50);
            btb_lookup_pc = 32'h600 + 4 * $urandom_range(0, 8);
            cyc();
        end
        clr(); cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
